if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), instruction word presented for bubbles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Stall  input  1  hold IF/ID register; from load-use hazard logic.
REQ-006 Redirect  input  1  taken branch/jump resolved downstream; flush and refetch.
REQ-007 RedirectPC  input  32  target address when Redirect=1.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  32  fetch address, equals PC.
REQ-010 imem_ready  input  1  request completes this cycle; imem_rdata valid in same cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 IF_ID_PC  output  32  PC of instruction held in IF/ID.
REQ-013 IF_ID_Instruction  output  32  instruction word feeding the decoder.
REQ-014 IF_ID_Valid  output  1  IF/ID holds a real instruction.

Function
REQ-015 States: FETCH (imem_req=1) and HOLD (imem_req=0, one fetched word buffered); one outstanding request maximum.
REQ-016 imem_addr SHALL equal PC every cycle; PC[1:0] always 2'b00; RedirectPC[1:0] ignored.
REQ-017 Priority per cycle: Redirect > Stall > normal fetch.
REQ-018 Redirect (any state): PC<=RedirectPC, IF/ID<=bubble, holding buffer discarded, imem_rdata that cycle discarded, next state FETCH.
REQ-019 FETCH, imem_ready=1, Stall=0: IF/ID<={PC, imem_rdata, 1}, PC<=PC+4, stay FETCH.
REQ-020 FETCH, imem_ready=1, Stall=1: buffer<={PC, imem_rdata}, PC<=PC+4, IF/ID unchanged, go HOLD.
REQ-021 FETCH, imem_ready=0, Stall=0: IF/ID<=bubble, PC unchanged; Stall=1: IF/ID unchanged.
REQ-022 HOLD, Stall=1: all state unchanged; Stall=0: IF/ID<={buffer,1}, go FETCH (new request issued that cycle's following edge onward).
REQ-023 Bubble = {IF_ID_PC unchanged, IF_ID_Instruction=NOP_INSTR, IF_ID_Valid=0}; IF_ID_Instruction SHALL be NOP_INSTR whenever IF_ID_Valid=0.
REQ-024 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-025 Redirect aborts an in-flight request; imem_addr may change without imem_ready; memory is required to accept abort.
REQ-026 Throughput: one instruction per cycle when imem_ready=1 continuously and Stall=0; fetch-to-IF/ID latency one edge.

Reset
REQ-027 Asserting reset SHALL immediately (no clock) set PC=RESET_PC, state=FETCH, IF_ID_PC=RESET_PC, IF_ID_Instruction=NOP_INSTR, IF_ID_Valid=0, buffer cleared.
REQ-028 Reset mid-request or in HOLD SHALL drop the request/buffer; first fetch after release is RESET_PC, imem_req=1 during reset.
REQ-029 Performance counters (if compiled) SHALL reset to 0.

Configuration
REQ-030 Macro IF_STAGE_PERF_CNT_EN: when defined, adds outputs fetch_count (32, increments on each instruction loaded valid into IF/ID) and stall_count (32, increments each cycle Stall=1 and Redirect=0), both wrapping at 2^32.
REQ-031 Without IF_STAGE_PERF_CNT_EN: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset release, imem_ready=1 always, rdata=addr-derived: IF_ID_PC sequence 0,4,8,12 on consecutive cycles, Valid=1 from first edge after release.
REQ-033 Stall=1 for 3 cycles while imem_ready=1 at PC=0x10: one word buffered (HOLD), imem_req=0, IF/ID holds 0x0C; Stall release -> IF/ID=0x10 next edge, then 0x14, no instruction lost or duplicated.
REQ-034 Redirect=1, RedirectPC=0x0000_0203 while imem_ready=1 and Stall=1: IF/ID bubble (Instruction=0x00000013, Valid=0), next imem_addr=0x0000_0200.
REQ-035 imem_ready held 0 for 4 cycles, Stall=0: four bubbles, PC constant; then ready=1 -> IF/ID valid with that PC.
REQ-036 PC=0xFFFF_FFFC fetched: next imem_addr=0x0000_0000; async reset asserted mid-cycle in HOLD -> outputs at reset values before next edge.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, single-outstanding fetch request and IF/ID pipeline register.
// Optional performance counters are compiled in with `define IF_STAGE_PERF_CNT_EN.
//
// state | meaning
// FETCH | request outstanding, imem_addr = PC
// HOLD  | no request, one fetched word buffered while decode stalls
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instruction,
`ifdef IF_STAGE_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        IF_ID_Valid
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] buf_pc, buf_pc_n;
  logic [31:0] buf_instr, buf_instr_n;
  logic [31:0] id_pc, id_pc_n;
  logic [31:0] id_instr, id_instr_n;
  logic        id_valid, id_valid_n;
  logic        load_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_PC & ALIGN_MASK;
      buf_pc    <= 32'h0;
      buf_instr <= 32'h0;
      id_pc     <= RESET_PC;
      id_instr  <= NOP_INSTR;
      id_valid  <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      buf_pc    <= buf_pc_n;
      buf_instr <= buf_instr_n;
      id_pc     <= id_pc_n;
      id_instr  <= id_instr_n;
      id_valid  <= id_valid_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    buf_pc_n    = buf_pc;
    buf_instr_n = buf_instr;
    id_pc_n     = id_pc;
    id_instr_n  = id_instr;
    id_valid_n  = id_valid;
    load_valid  = 1'b0;

    if (Redirect) begin
      // Abort whatever is in flight; the returned word this cycle is dropped.
      pc_n        = RedirectPC & ALIGN_MASK;
      id_instr_n  = NOP_INSTR;
      id_valid_n  = 1'b0;
      buf_pc_n    = 32'h0;
      buf_instr_n = 32'h0;
      state_n     = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            pc_n = pc + 32'd4;
            if (Stall) begin
              buf_pc_n    = pc;
              buf_instr_n = imem_rdata;
              state_n     = HOLD;
            end else begin
              id_pc_n    = pc;
              id_instr_n = imem_rdata;
              id_valid_n = 1'b1;
              load_valid = 1'b1;
            end
          end else if (!Stall) begin
            id_instr_n = NOP_INSTR;
            id_valid_n = 1'b0;
          end
        end
        HOLD: begin
          if (!Stall) begin
            id_pc_n    = buf_pc;
            id_instr_n = buf_instr;
            id_valid_n = 1'b1;
            load_valid = 1'b1;
            state_n    = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  assign imem_req          = (state == FETCH);
  assign imem_addr         = pc;
  assign IF_ID_PC          = id_pc;
  assign IF_ID_Instruction = id_instr;
  assign IF_ID_Valid       = id_valid;

`ifdef IF_STAGE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (load_valid) fetch_count <= fetch_count + 32'd1;
      if (Stall && !Redirect) stall_count <= stall_count + 32'd1;
    end
  end
`else
  logic unused_load_valid;
  assign unused_load_valid = load_valid;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized stall/redirect/ready traffic,
// checked against a queue-based reference model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall, Redirect, imem_ready;
  logic [31:0] RedirectPC;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, IF_ID_PC, IF_ID_Instruction;
  logic        IF_ID_Valid;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int checks = 0;
  int failures = 0;

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IF_ID_PC(IF_ID_PC), .IF_ID_Instruction(IF_ID_Instruction),
`ifdef IF_STAGE_PERF_CNT_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .IF_ID_Valid(IF_ID_Valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234} | 32'h0000_0100;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Reference model: PC, a queue holding at most one parked word, and the IF/ID triple.
  logic [31:0] m_pc, m_id_pc, m_id_ins;
  logic        m_id_v;
  logic [63:0] m_parked[$];
  logic [31:0] m_fetches, m_stalls;

  task automatic model_reset();
    m_pc = RESET_PC; m_id_pc = RESET_PC; m_id_ins = NOP_INSTR; m_id_v = 1'b0;
    m_parked.delete(); m_fetches = 0; m_stalls = 0;
  endtask

  task automatic model_edge();
    logic [63:0] w;
    if (Stall && !Redirect) m_stalls += 1;
    if (Redirect) begin
      m_pc = {RedirectPC[31:2], 2'b00};
      m_id_ins = NOP_INSTR; m_id_v = 1'b0;
      m_parked.delete();
    end else if (m_parked.size() != 0) begin
      if (!Stall) begin
        w = m_parked.pop_front();
        m_id_pc = w[63:32]; m_id_ins = w[31:0]; m_id_v = 1'b1; m_fetches += 1;
      end
    end else if (imem_ready) begin
      if (Stall) m_parked.push_back({m_pc, mem_word(m_pc)});
      else begin
        m_id_pc = m_pc; m_id_ins = mem_word(m_pc); m_id_v = 1'b1; m_fetches += 1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!Stall) begin
      m_id_ins = NOP_INSTR; m_id_v = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_req"}, {31'h0, imem_req}, {31'h0, m_parked.size() == 0});
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".if_id_pc"}, IF_ID_PC, m_id_pc);
    chk({tag, ".if_id_instr"}, IF_ID_Instruction, m_id_ins);
    chk({tag, ".if_id_valid"}, {31'h0, IF_ID_Valid}, {31'h0, m_id_v});
`ifdef IF_STAGE_PERF_CNT_EN
    chk({tag, ".fetch_count"}, fetch_count, m_fetches);
    chk({tag, ".stall_count"}, stall_count, m_stalls);
`endif
  endtask

  // One clock: model consumes the inputs present before the edge, outputs sampled 1 unit after.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    Stall = st; Redirect = rd; RedirectPC = rpc; imem_ready = rdy;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all("reset");
    reset = 1'b0;

    // Streaming fetch from reset: IF/ID PC 0,4,8,12.
    for (int i = 0; i < 4; i++) begin
      step("stream");
      chk("stream.pc_seq", IF_ID_PC, 32'(i * 4));
      chk("stream.valid", {31'h0, IF_ID_Valid}, 32'h1);
    end

    // Stall three cycles at PC 0x10 with memory ready.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.hold_pc", IF_ID_PC, 32'h0000_000C);
      chk("stall.no_req", {31'h0, imem_req}, 32'h0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    step("unstall0");
    chk("unstall.pc10", IF_ID_PC, 32'h0000_0010);
    step("unstall1");
    chk("unstall.pc14", IF_ID_PC, 32'h0000_0014);

    // Redirect beats stall; low address bits dropped.
    drive(1'b1, 1'b1, 32'h0000_0203, 1'b1);
    step("redirect");
    chk("redirect.addr", imem_addr, 32'h0000_0200);
    chk("redirect.nop", IF_ID_Instruction, NOP_INSTR);
    chk("redirect.valid", {31'h0, IF_ID_Valid}, 32'h0);

    // Memory not ready four cycles: bubbles, PC steady, then valid at that PC.
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("notready");
      chk("notready.addr", imem_addr, 32'h0000_0200);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    step("ready_again");
    chk("ready_again.pc", IF_ID_PC, 32'h0000_0200);

    // PC wrap at top of address space.
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    step("wrap_redirect");
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    step("wrap");
    chk("wrap.addr", imem_addr, 32'h0000_0000);
    chk("wrap.id_pc", IF_ID_PC, 32'hFFFF_FFFC);

    // Enter HOLD, then assert reset between edges.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step("into_hold");
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    step("after_reset");
    chk("after_reset.first_pc", IF_ID_PC, RESET_PC);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom(),
            $urandom_range(0, 9) < 7);
      step("random");
      if (!IF_ID_Valid) chk("random.nop_when_invalid", IF_ID_Instruction, NOP_INSTR);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
